// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_RESP_I,
    ARB_RESP_D
  } arb_state_t;

  typedef enum logic {
    OWNER_INST,
    OWNER_DATA
  } arb_owner_t;

  localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/arb_pick.sv
// Winner select between fetch and load/store requests.
// Build option ARB_ROUND_ROBIN_EN: alternate on collisions instead of data-first.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  arb_owner_t last_owner,
`endif
  output logic       pick_i,
  output logic       pick_d
);

`ifdef ARB_ROUND_ROBIN_EN
  // On a collision the side that did not win last time goes first.
  assign pick_d = d_req && (!i_req || (last_owner == OWNER_INST));
`else
  assign pick_d = d_req;
`endif
  assign pick_i = i_req && !pick_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, 1-cycle-latency RAM between instruction fetch and load/store.
// Build option ARB_ROUND_ROBIN_EN selects round-robin collision handling (default: data first).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state;
  logic       idle;
  logic       pick_i;
  logic       pick_d;

  // Reset gates every strobe combinationally, so nothing leaks out in the reset cycle.
  assign idle = reset_n && (state == ARB_IDLE);

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_t last_owner;

  arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_owner (last_owner),
    .pick_i     (pick_i),
    .pick_d     (pick_d)
  );
`else
  arb_pick u_pick (
    .i_req  (i_req),
    .d_req  (d_req),
    .pick_i (pick_i),
    .pick_d (pick_d)
  );
`endif

  assign i_gnt     = idle && pick_i;
  assign d_gnt     = idle && pick_d;
  assign mem_en    = i_gnt || d_gnt;
  assign mem_we    = d_gnt && d_we;
  assign mem_be    = mem_we ? d_be : (mem_en ? BE_ALL : 4'h0);
  assign mem_addr  = mem_en ? ((d_gnt ? d_addr : i_addr) & ~ADDR_W'(3)) : '0;
  assign mem_wdata = mem_we ? d_wdata : '0;

  assign i_rvalid  = reset_n && (state == ARB_RESP_I);
  assign d_rvalid  = reset_n && (state == ARB_RESP_D);
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ARB_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner <= OWNER_DATA;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (i_gnt)
            state <= ARB_RESP_I;
          else if (d_gnt && !d_we)
            state <= ARB_RESP_D;
          else
            state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
`ifdef ARB_ROUND_ROBIN_EN
      if (i_gnt)
        last_owner <= OWNER_INST;
      else if (d_gnt)
        last_owner <= OWNER_DATA;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Environment RAM: 1 KiB, aliased by address bits [9:2], 1-cycle read latency.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[9:2]];
      end
    end
  end

  // Reference model: expected memory image, outstanding response, last winner.
  logic [31:0] ref_mem [256];
  int          resp_kind;      // 0 none, 1 fetch, 2 load
  logic [31:0] resp_data;
  logic        m_last_data;
  logic        got_i, got_d;
  logic [31:0] seen_i_rdata, seen_d_rdata;
  int          cyc, g_cyc_i, g_cyc_d, v_cyc_i, v_cyc_d;
  int          n_vec, n_err;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: check outputs at the negedge, advance the model, return #1 after posedge.
  task automatic step();
    logic        take_i, take_d, exp_iv, exp_dv;
    logic [31:0] exp_addr, word;
    @(negedge clk);
    take_i = 1'b0;
    take_d = 1'b0;
    exp_iv = 1'b0;
    exp_dv = 1'b0;
    if (reset_n) begin
      exp_iv = (resp_kind == 1);
      exp_dv = (resp_kind == 2);
      if (resp_kind == 0) begin
`ifdef ARB_ROUND_ROBIN_EN
        take_d = d_req && (!i_req || !m_last_data);
`else
        take_d = d_req;
`endif
        take_i = i_req && !take_d;
      end
    end
    exp_addr = take_d ? {d_addr[31:2], 2'b00} : (take_i ? {i_addr[31:2], 2'b00} : 32'h0);

    check("i_gnt", 32'(i_gnt), 32'(take_i));
    check("d_gnt", 32'(d_gnt), 32'(take_d));
    check("mem_en", 32'(mem_en), 32'(take_i || take_d));
    check("mem_we", 32'(mem_we), 32'(take_d && d_we));
    check("mem_addr", mem_addr, exp_addr);
    if (take_d && d_we) begin
      check("mem_be_st", 32'(mem_be), 32'(d_be));
      check("mem_wdata", mem_wdata, d_wdata);
    end else if (take_i) begin
      check("mem_be_if", 32'(mem_be), 32'hF);
      check("mem_wdata_if", mem_wdata, 32'h0);
    end else if (!take_d) begin
      check("mem_be_off", 32'(mem_be), 32'h0);
      check("mem_wdata_off", mem_wdata, 32'h0);
    end
    check("i_rvalid", 32'(i_rvalid), 32'(exp_iv));
    check("d_rvalid", 32'(d_rvalid), 32'(exp_dv));
    if (exp_iv) begin
      check("i_rdata", i_rdata, resp_data);
      seen_i_rdata = i_rdata;
      v_cyc_i = cyc;
    end
    if (exp_dv) begin
      check("d_rdata", d_rdata, resp_data);
      seen_d_rdata = d_rdata;
      v_cyc_d = cyc;
    end

    if (!reset_n) begin
      resp_kind   = 0;
      m_last_data = 1'b1;
    end else begin
      resp_kind = 0;
      if (take_d && d_we) begin
        word = ref_mem[d_addr[9:2]];
        for (int b = 0; b < 4; b++)
          if (d_be[b]) word[8*b +: 8] = d_wdata[8*b +: 8];
        ref_mem[d_addr[9:2]] = word;
      end else if (take_d) begin
        resp_kind = 2;
        resp_data = ref_mem[d_addr[9:2]];
      end else if (take_i) begin
        resp_kind = 1;
        resp_data = ref_mem[i_addr[9:2]];
      end
      if (take_i) m_last_data = 1'b0;
      if (take_d) m_last_data = 1'b1;
    end
    got_i = take_i;
    got_d = take_d;
    if (take_i) g_cyc_i = cyc;
    if (take_d) g_cyc_d = cyc;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Run until both requesters are served and no read is outstanding.
  task automatic drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    while ((i_req || d_req || resp_kind != 0) && n < max_cyc) begin
      step();
      n++;
      if (got_i) i_req = 1'b0;
      if (got_d) d_req = 1'b0;
    end
    if (i_req || d_req || resp_kind != 0) check({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic set_d(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    d_req = 1'b1; d_we = we; d_be = be; d_addr = a; d_wdata = wd;
  endtask

  task automatic set_i(input logic [31:0] a);
    i_req = 1'b1; i_addr = a;
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    resp_kind = 0; resp_data = '0; m_last_data = 1'b1;
    got_i = 1'b0; got_d = 1'b0;
    seen_i_rdata = '0; seen_d_rdata = '0;
    g_cyc_i = 0; g_cyc_d = 0; v_cyc_i = 0; v_cyc_d = 0;
    for (int k = 0; k < 256; k++) begin
      ram[k]     = 32'hA5000000 | 32'(k);
      ref_mem[k] = 32'hA5000000 | 32'(k);
    end
    ram[8'h04] = 32'h00100093;  ref_mem[8'h04] = 32'h00100093;   // byte 0x10
    ram[8'h80] = 32'h12345678;  ref_mem[8'h80] = 32'h12345678;   // byte 0x200
    mem_rdata = '0;

    // Reset with both requests raised: nothing may be granted or strobed.
    reset_n = 1'b0;
    set_i(32'h10);
    set_d(1'b1, 4'hF, 32'h300, 32'hDEADBEEF);
    step();
    step();
    check("rst_gnt", 32'({i_gnt, d_gnt, mem_en, mem_we, i_rvalid, d_rvalid}), 32'h0);
    i_req = 1'b0; d_req = 1'b0;
    reset_n = 1'b1;
    step();

    // Fetch only.
    set_i(32'h10);
    drain("fetch", 10);
    check("fetch_data", seen_i_rdata, 32'h00100093);
    check("fetch_lat", 32'(v_cyc_i - g_cyc_i), 32'd1);
    step();

    // Partial store then load of the same word.
    set_d(1'b1, 4'b1100, 32'h202, 32'hABCD0000);
    drain("store", 10);
    set_d(1'b0, 4'h0, 32'h200, 32'h0);
    drain("load", 10);
    check("st_ld_data", seen_d_rdata, 32'hABCD5678);

    // Collision: load and fetch raised together.
    set_d(1'b0, 4'h0, 32'h40, 32'h0);
    set_i(32'h44);
    drain("collide", 10);
`ifndef ARB_ROUND_ROBIN_EN
    check("coll_gap", 32'(g_cyc_i - g_cyc_d), 32'd2);
`endif
    check("coll_dlat", 32'(v_cyc_d - g_cyc_d), 32'd1);
    check("coll_ilat", 32'(v_cyc_i - g_cyc_i), 32'd1);

    // Reset lands while a fetch is in flight: its rvalid must be dropped.
    set_i(32'h80);
    step();
    i_req = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    // Back-to-back stores, one per cycle, then read them back.
    for (int k = 0; k < 3; k++) begin
      set_d(1'b1, 4'hF, 32'(4 * k), 32'hC0DE0000 | 32'(k));
      step();
      check("b2b_gnt", 32'(got_d), 32'd1);
    end
    d_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_d(1'b0, 4'h0, 32'(4 * k), 32'h0);
      drain("b2b_rd", 10);
      check("b2b_data", seen_d_rdata, 32'hC0DE0000 | 32'(k));
    end

    // Random traffic, including occasional resets.
    for (int t = 0; t < 600; t++) begin
      if (!i_req && $urandom_range(0, 2) != 0) set_i($urandom);
      if (!d_req && $urandom_range(0, 2) != 0)
        set_d(1'($urandom), 4'($urandom), $urandom, $urandom);
      reset_n = ($urandom_range(0, 59) != 0);
      step();
      if (got_i) i_req = 1'b0;
      if (got_d) d_req = 1'b0;
    end
    reset_n = 1'b1;
    drain("final", 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the core's instruction-fetch port and its load/store port.
- The RAM has a 1-cycle read latency.
- Sits between the multicycle RV32I core and the unified memory. It replaces the separate ROM path, so fetch and data live in one array.
- Sequences at most one outstanding access and returns read data with a valid pulse.

Parameters:
ADDR_W, 32, byte-address width of both requester ports and the memory port
DATA_W, 32, data width; must be 32 (byte enables are 4 bits)

Ports:
clk  input  1  clock
reset_n  input  1  reset, synchronous, active-low
i_req  input  1  instruction fetch request; held until i_gnt
i_addr  input  ADDR_W  fetch byte address; stable while i_req
i_gnt  output  1  fetch accepted this cycle
i_rvalid  output  1  fetch data valid, one-cycle pulse
i_rdata  output  DATA_W  fetch data
d_req  input  1  data request; held until d_gnt
d_we  input  1  1 = store, 0 = load
d_be  input  4  store byte enables (ignored for loads)
d_addr  input  ADDR_W  data byte address
d_wdata  input  DATA_W  store data, already lane-aligned
d_gnt  output  1  data access accepted this cycle
d_rvalid  output  1  load data valid, one-cycle pulse
d_rdata  output  DATA_W  load data (full word; core extracts byte/halfword)
mem_en  output  1  RAM access strobe
mem_we  output  1  RAM write
mem_be  output  4  RAM byte enables
mem_addr  output  ADDR_W  RAM byte address, bits [1:0] forced to 0
mem_wdata  output  DATA_W  RAM write data
mem_rdata  input  DATA_W  RAM read data, valid the cycle after mem_en && !mem_we

Behaviour:
- States:
  - ARB_IDLE: may grant.
  - ARB_RESP_I: fetch read in flight.
  - ARB_RESP_D: load read in flight.
- Reset: while reset_n low at a clock edge, state <= ARB_IDLE and last_owner <= DATA.
- Reset gating: i_gnt, d_gnt, mem_en, mem_we, i_rvalid and d_rvalid are forced 0 combinationally while reset_n is low. mem_be = 0, mem_addr = 0, mem_wdata = 0 when mem_en = 0.
- Grant in ARB_IDLE (combinational):
  - Winner = data if d_req, else fetch if i_req (fixed priority, data first).
  - Winner's gnt = 1; mem_en = 1; mem_addr/mem_be/mem_wdata/mem_we are driven from the winner.
  - A fetch drives mem_we = 0 and mem_be = 4'hF.
- Next state from ARB_IDLE:
  - Fetch grant -> ARB_RESP_I.
  - Load grant -> ARB_RESP_D.
  - Store grant -> ARB_IDLE (store completes at the grant edge, no rvalid).
  - No request -> ARB_IDLE.
- ARB_RESP_I: i_rvalid = 1, i_rdata = mem_rdata; no grant, mem_en = 0; next ARB_IDLE.
- ARB_RESP_D: d_rvalid = 1, d_rdata = mem_rdata; no grant; next ARB_IDLE.
- Latency and throughput:
  - Read: gnt at cycle N, rvalid at N+1.
  - Store: gnt at N, RAM written at the N edge.
  - Peak rate: one read per 2 cycles, one store per cycle.
- i_rdata and d_rdata are don't-care when their rvalid is 0. The bench must check them only under rvalid.
- Simultaneous i_req and d_req: data wins; i_req stays pending and is granted at the next ARB_IDLE cycle.
- A requester dropping req before gnt is a protocol violation. Behaviour is undefined; there is no assertion.
- Reset asserted in ARB_RESP_x: the pending rvalid is not produced; the next state is ARB_IDLE.
- Misaligned address: bits [1:0] are dropped. The core is responsible for alignment and lane steering.
- Address wrap: no range check; the address passes straight through.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: a last_owner register is updated on every grant. When both requests are high in ARB_IDLE, the requester that is not last_owner wins. A single requester always wins.
- Undefined: fixed data-first priority; last_owner is not instantiated.

Decomposition:
- Package mem_arb_pkg:
  - enum arb_state_t {ARB_IDLE, ARB_RESP_I, ARB_RESP_D}
  - enum arb_owner_t {OWNER_INST, OWNER_DATA}
  - localparam BE_ALL = 4'hF
- Sub-module arb_pick (combinational winner select from i_req, d_req, last_owner) is natural. It isolates the ARB_ROUND_ROBIN_EN logic.

Test Plan:
- Fetch only: i_req=1, i_addr=0x10, RAM[0x10]=0x00100093 -> i_gnt at cycle N, i_rvalid=1 with i_rdata=0x00100093 at N+1, idle at N+2.
- Store then load: d_we=1, d_addr=0x202, d_be=4'b1100, d_wdata=0xABCD0000 over RAM word 0x12345678; then load 0x200 -> mem_addr=0x200 on the store, d_gnt=1 with no d_rvalid; load returns d_rdata=0xABCD5678.
- Collision, fixed priority: i_req and d_req (load 0x40) both high at N -> d_gnt at N, d_rvalid at N+1, i_gnt at N+2, i_rvalid at N+3.
- Collision with ARB_ROUND_ROBIN_EN: both requests high continuously for 4 grants -> grant order data, inst, data, inst.
- Reset mid-read: fetch granted at N, reset_n=0 at the N+1 edge -> no i_rvalid, state ARB_IDLE, all gnt/valid 0 while reset low.
- Back-to-back stores: d_req with d_we=1 for 3 cycles, addresses 0x0, 0x4, 0x8 -> d_gnt=1 on 3 consecutive cycles, readback shows all 3 words written.
